conv_encoder_framer: RTL

//   Transmit-side partner of the K=3 Viterbi decoder. Buffers a frame of up to FRAME_LEN info

---
 rtl/viterbi_pkg.sv | 21 ++
 rtl/conv_enc_core.sv | 35 +++
 rtl/conv_encoder_framer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Constants and helpers shared by the K=3 rate-1/2 convolutional encoder and its Viterbi decoder.
// Symbol layout: [1]=G0 parity, [0]=G1 parity; register vector r = {s[1], s[0], b}.
package viterbi_pkg;

  localparam int K     = 3;
  localparam int SYM_W = 2;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ENCODE,
    ST_TAIL
  } state_e;

  function automatic logic [SYM_W-1:0] conv_sym(input logic [K-1:0] r);
    return {^(r & G0), ^(r & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Two-bit shift-state register plus parity generators; symbol for bit_i is combinational from the current state.
// The state shifts in bit_i on advance_i; clear_i has priority and zeroes the state.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_i,
  input  logic             advance_i,
  input  logic             clear_i,
  output logic [SYM_W-1:0] sym_o
);

  logic [K-2:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (clear_i) begin
      s_d = '0;
    end else if (advance_i) begin
      s_d = {s_q[0], bit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign sym_o = conv_sym({s_q, bit_i});

endmodule

// File: rtl/conv_encoder_framer.sv
// Frame buffer + FSM that replays buffered info bits through conv_enc_core as a registered symbol stream.
// Output register is only reloaded on a handshake, so a stalled symbol stays put until out_ready.
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 32,
  parameter bit TAIL_EN   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_bit,
  output logic                         in_ready,
  input  logic                         start,
  output logic [SYM_W-1:0]             out_sym,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic [$clog2(FRAME_LEN):0]   bit_count
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = AW + 1;

  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_count_q, bit_count_d;
  logic [CW-1:0]          idx_q, idx_d;
  logic                   tail_q, tail_d;
  logic [FRAME_LEN-1:0]   buf_q, buf_d;
  logic                   out_vld_q, out_vld_d;
  logic [SYM_W-1:0]       out_sym_q, out_sym_d;
  logic                   frame_done_q, frame_done_d;

  logic                   enc_bit, enc_adv, enc_clr;
  logic [SYM_W-1:0]       enc_sym;
  logic                   in_rdy;
  logic                   hs;
  logic                   finish;

  conv_enc_core u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_i     (enc_bit),
    .advance_i (enc_adv),
    .clear_i   (enc_clr),
    .sym_o     (enc_sym)
  );

  assign hs = out_vld_q && out_ready;

  always_comb begin
    state_d      = state_q;
    bit_count_d  = bit_count_q;
    idx_d        = idx_q;
    tail_d       = tail_q;
    buf_d        = buf_q;
    out_vld_d    = out_vld_q;
    out_sym_d    = out_sym_q;
    frame_done_d = 1'b0;
    enc_bit      = 1'b0;
    enc_adv      = 1'b0;
    enc_clr      = 1'b0;
    in_rdy       = 1'b0;
    finish       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        // Encoder state is held at zero while idle so every frame starts clean.
        enc_clr = 1'b1;
        in_rdy  = (bit_count_q < CW'(FRAME_LEN)) && !start && !frame_done_q;
        if (start) begin
          if (bit_count_q != '0) begin
            enc_clr   = 1'b0;
            enc_bit   = buf_q[0];
            enc_adv   = 1'b1;
            out_vld_d = 1'b1;
            out_sym_d = enc_sym;
            idx_d     = CW'(1);
            tail_d    = 1'b0;
            state_d   = ST_ENCODE;
          end else begin
            frame_done_d = 1'b1;
          end
        end else if (in_valid && in_rdy) begin
          buf_d[bit_count_q[AW-1:0]] = in_bit;
          bit_count_d                = bit_count_q + CW'(1);
        end
      end
      ST_ENCODE: begin
        if (hs) begin
          if (idx_q < bit_count_q) begin
            enc_bit   = buf_q[idx_q[AW-1:0]];
            enc_adv   = 1'b1;
            out_sym_d = enc_sym;
            idx_d     = idx_q + CW'(1);
          end else if (TAIL_EN) begin
            enc_adv   = 1'b1;
            out_sym_d = enc_sym;
            tail_d    = 1'b0;
            state_d   = ST_TAIL;
          end else begin
            finish = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        // tail_q marks that the second flush symbol is already in the output register.
        if (hs) begin
          if (!tail_q) begin
            enc_adv   = 1'b1;
            out_sym_d = enc_sym;
            tail_d    = 1'b1;
          end else begin
            finish = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    if (finish) begin
      out_vld_d    = 1'b0;
      out_sym_d    = '0;
      frame_done_d = 1'b1;
      bit_count_d  = '0;
      idx_d        = '0;
      tail_d       = 1'b0;
      enc_clr      = 1'b1;
      state_d      = ST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      bit_count_q  <= '0;
      idx_q        <= '0;
      tail_q       <= 1'b0;
      buf_q        <= '0;
      out_vld_q    <= 1'b0;
      out_sym_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      idx_q        <= idx_d;
      tail_q       <= tail_d;
      buf_q        <= buf_d;
      out_vld_q    <= out_vld_d;
      out_sym_q    <= out_sym_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_rdy;
  assign out_sym    = out_sym_q;
  assign out_valid  = out_vld_q;
  assign busy       = (state_q != ST_LOAD);
  assign frame_done = frame_done_q;
  assign bit_count  = bit_count_q;

endmodule
